// File: rtl/oldestn_arbiter_bps_pkg.sv
// Shared RCU definitions for the oldest-first N-grant arbiter: window geometry and lane/slot defaults.
package oldestn_arbiter_bps_pkg;

  localparam int unsigned PRIORITY_WIDTH_DEF = 3;
  localparam int unsigned SEL_WIDTH_DEF      = 1 << PRIORITY_WIDTH_DEF;
  localparam int unsigned GRANT_NUM_DEF      = 2;
  localparam int unsigned BPS_NUM_DEF        = 2;

  typedef logic [PRIORITY_WIDTH_DEF-1:0] win_idx_t;

endpackage

// File: rtl/oldestn_arbiter_bps_picker.sv
// Combinational oldest-first picker: rotates the window to age order, appends bypass lanes
// (younger than every stored entry) and peels off up to GRANT_NUM winners.
module oldestn_picker
  import oldestn_arbiter_bps_pkg::*;
#(
  parameter int unsigned SEL_WIDTH      = SEL_WIDTH_DEF,
  parameter int unsigned PRIORITY_WIDTH = PRIORITY_WIDTH_DEF,
  parameter int unsigned GRANT_NUM      = GRANT_NUM_DEF,
  parameter int unsigned BPS_NUM        = BPS_NUM_DEF
) (
  input  logic [SEL_WIDTH-1:0]                          cand,
  input  logic [PRIORITY_WIDTH-1:0]                     head,
  input  logic [BPS_NUM-1:0]                            bps_valid,
  input  logic [BPS_NUM*PRIORITY_WIDTH-1:0]             bps_index,
  output logic [GRANT_NUM-1:0][SEL_WIDTH+BPS_NUM-1:0]   slot_onehot_c,
  output logic [GRANT_NUM-1:0]                          slot_valid_c,
  output logic [GRANT_NUM*PRIORITY_WIDTH-1:0]           slot_index_c,
  output logic [GRANT_NUM-1:0]                          slot_bps_c
);

  localparam int unsigned CW = SEL_WIDTH + BPS_NUM;

  // Bit a of the candidate vector is the entry of age a; bypass lanes sit above the oldest-to-youngest window.
  always_comb begin
    logic [CW-1:0]             remain;
    logic [CW-1:0]             pick;
    logic [PRIORITY_WIDTH-1:0] pos;
    logic                      found;
    remain        = '0;
    pick          = '0;
    pos           = '0;
    found         = 1'b0;
    slot_onehot_c = '0;
    slot_valid_c  = '0;
    slot_index_c  = '0;
    slot_bps_c    = '0;

    for (int a = 0; a < SEL_WIDTH; a++) begin
      pos       = PRIORITY_WIDTH'(a) + head;
      remain[a] = cand[pos];
    end
    remain[SEL_WIDTH +: BPS_NUM] = bps_valid;

    for (int s = 0; s < GRANT_NUM; s++) begin
      pick  = '0;
      found = 1'b0;
      for (int b = 0; b < CW; b++) begin
        if (!found && remain[b]) begin
          pick[b] = 1'b1;
          found   = 1'b1;
        end
      end
      remain           = remain & ~pick;
      slot_onehot_c[s] = pick;
      slot_valid_c[s]  = found;
      slot_bps_c[s]    = |pick[SEL_WIDTH +: BPS_NUM];

      for (int a = 0; a < SEL_WIDTH; a++) begin
        if (pick[a]) begin
          slot_index_c[s*PRIORITY_WIDTH +: PRIORITY_WIDTH] = PRIORITY_WIDTH'(a) + head;
        end
      end
      for (int l = 0; l < BPS_NUM; l++) begin
        if (pick[SEL_WIDTH+l]) begin
          slot_index_c[s*PRIORITY_WIDTH +: PRIORITY_WIDTH] = bps_index[l*PRIORITY_WIDTH +: PRIORITY_WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/oldestn_arbiter_bps.sv
// Registered N-grant oldest-first arbiter with same-cycle bypass lanes for the RCU window.
// Holds a pending-ready bitmap and a valid/ready grant register; losing bypass requests are parked in the bitmap.
module oldestn_arbiter_bps
  import oldestn_arbiter_bps_pkg::*;
#(
  parameter int unsigned SEL_WIDTH      = SEL_WIDTH_DEF,
  parameter int unsigned PRIORITY_WIDTH = PRIORITY_WIDTH_DEF,
  parameter int unsigned GRANT_NUM      = GRANT_NUM_DEF,
  parameter int unsigned BPS_NUM        = BPS_NUM_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PRIORITY_WIDTH-1:0]           priority_fix_i,
  input  logic [SEL_WIDTH-1:0]                req_set_i,
  input  logic                                flush_i,
  input  logic [BPS_NUM-1:0]                  new_req_valid_i,
  input  logic [BPS_NUM*PRIORITY_WIDTH-1:0]   new_req_index_i,
  output logic [BPS_NUM-1:0]                  new_grant_o,
  output logic [GRANT_NUM-1:0]                grant_valid_o,
  output logic [GRANT_NUM*PRIORITY_WIDTH-1:0] grant_index_o,
  output logic [GRANT_NUM-1:0]                grant_bps_o,
  input  logic                                grant_ready_i,
  output logic [SEL_WIDTH-1:0]                pending_o
);

  localparam int unsigned CW = SEL_WIDTH + BPS_NUM;

  logic [SEL_WIDTH-1:0]                pending_q;
  logic                                load_c;
  logic [GRANT_NUM-1:0][CW-1:0]        slot_onehot_c;
  logic [GRANT_NUM-1:0]                slot_valid_c;
  logic [GRANT_NUM*PRIORITY_WIDTH-1:0] slot_index_c;
  logic [GRANT_NUM-1:0]                slot_bps_c;
  logic [SEL_WIDTH-1:0]                granted_c;
  logic [BPS_NUM-1:0]                  lane_win_c;
  logic [SEL_WIDTH-1:0]                lost_c;
  logic [SEL_WIDTH-1:0]                bps_mask_c;
  logic                                bps_dup_c;
  logic [SEL_WIDTH-1:0]                pending_next_c;

  assign load_c    = ~(|grant_valid_o) | grant_ready_i;
  assign pending_o = pending_q;

  oldestn_picker #(
    .SEL_WIDTH      (SEL_WIDTH),
    .PRIORITY_WIDTH (PRIORITY_WIDTH),
    .GRANT_NUM      (GRANT_NUM),
    .BPS_NUM        (BPS_NUM)
  ) u_picker (
    .cand          (pending_q),
    .head          (priority_fix_i),
    .bps_valid     (new_req_valid_i),
    .bps_index     (new_req_index_i),
    .slot_onehot_c (slot_onehot_c),
    .slot_valid_c  (slot_valid_c),
    .slot_index_c  (slot_index_c),
    .slot_bps_c    (slot_bps_c)
  );

  // Fold the per-slot one-hots back from age order into window-index order.
  always_comb begin
    logic [CW-1:0]             taken;
    logic [PRIORITY_WIDTH-1:0] pos;
    taken     = '0;
    pos       = '0;
    granted_c = '0;
    for (int s = 0; s < GRANT_NUM; s++) begin
      taken = taken | slot_onehot_c[s];
    end
    for (int a = 0; a < SEL_WIDTH; a++) begin
      pos            = PRIORITY_WIDTH'(a) + priority_fix_i;
      granted_c[pos] = taken[a];
    end
    lane_win_c = taken[SEL_WIDTH +: BPS_NUM];
  end

  // Lane grants, parked losers and the next pending bitmap.
  always_comb begin
    logic [PRIORITY_WIDTH-1:0] idx;
    idx            = '0;
    new_grant_o    = '0;
    lost_c         = '0;
    bps_mask_c     = '0;
    bps_dup_c      = 1'b0;
    pending_next_c = '0;

    if (!rst && !flush_i && load_c) begin
      new_grant_o = lane_win_c;
    end

    for (int l = 0; l < BPS_NUM; l++) begin
      if (new_req_valid_i[l]) begin
        idx = new_req_index_i[l*PRIORITY_WIDTH +: PRIORITY_WIDTH];
        if (bps_mask_c[idx]) begin
          bps_dup_c = 1'b1;
        end
        bps_mask_c[idx] = 1'b1;
        if (!new_grant_o[l]) begin
          lost_c[idx] = 1'b1;
        end
      end
    end

    pending_next_c = (pending_q & ~(load_c ? granted_c : '0)) | req_set_i | lost_c;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      pending_q     <= '0;
      grant_valid_o <= '0;
      grant_index_o <= '0;
      grant_bps_o   <= '0;
    end else begin
      pending_q <= pending_next_c;
      if (load_c) begin
        grant_valid_o <= slot_valid_c;
        grant_index_o <= slot_index_c;
        grant_bps_o   <= slot_bps_c;
      end
    end
  end

  // Caller contract: bypass indices are unique and never already pending or arriving via req_set_i.
  a_bps_unique: assert property (@(posedge clk) disable iff (rst || flush_i) !bps_dup_c);
  a_bps_fresh:  assert property (@(posedge clk) disable iff (rst || flush_i)
                                 (bps_mask_c & (pending_q | req_set_i)) == '0);
  a_set_fresh:  assert property (@(posedge clk) disable iff (rst || flush_i)
                                 (req_set_i & pending_q) == '0);

endmodule

// File: doc/oldestn_arbiter_bps.md
Name: oldestn_arbiter_bps

Overview:
Registered N-grant oldest-first arbiter for the RCU issue/commit window. It keeps a pending-ready bitmap over a circular window of SEL_WIDTH entries, with age set by the head pointer priority_fix_i. Each cycle it selects up to GRANT_NUM oldest candidates, including BPS_NUM same-cycle bypass requests that rank younger than all stored entries. Grants are held in an output register with a valid/ready handshake; bypass requests that lose arbitration are captured into the bitmap and are never dropped.

Parameters:
SEL_WIDTH, 8, window entries; must equal 2**PRIORITY_WIDTH
PRIORITY_WIDTH, 3, index width
GRANT_NUM, 2, grant slots per cycle (1..4)
BPS_NUM, 2, bypass request lanes (1..4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
priority_fix_i  in  PRIORITY_WIDTH  head (oldest) index of the window
req_set_i  in  SEL_WIDTH  entries becoming ready; enter the bitmap next cycle
flush_i  in  1  kill all pending and held grants
new_req_valid_i  in  BPS_NUM  bypass request valid per lane
new_req_index_i  in  BPS_NUM*PRIORITY_WIDTH  window index per bypass lane
new_grant_o  out  BPS_NUM  combinational: lane selected this cycle
grant_valid_o  out  GRANT_NUM  registered slot valid
grant_index_o  out  GRANT_NUM*PRIORITY_WIDTH  registered slot index
grant_bps_o  out  GRANT_NUM  slot came from a bypass lane
grant_ready_i  in  1  consumer accepts the whole grant bundle
pending_o  out  SEL_WIDTH  current pending bitmap

Behaviour:
- Reset (rst=1 at a clk edge): pending=0, grant_valid_o=0, grant_index_o=0, grant_bps_o=0. new_grant_o=0 while rst=1.
- load = ~(|grant_valid_o) | grant_ready_i. Arbitration takes effect only when load=1.
- Candidate order when load=1:
  - First, pending bits ranked by age = (idx - priority_fix_i) mod SEL_WIDTH, ascending. Wrap-around is required.
  - Then bypass lanes in lane order 0..BPS_NUM-1, valid lanes only.
- The first min(GRANT_NUM, #candidates) candidates fill slots 0..k-1, oldest first. Slots k.. get valid=0, index=0, bps=0.
- new_grant_o[l] = load & lane l placed in a slot. It is combinational and the same cycle as new_req_valid_i.
- Registered outputs:
  - On load, the slot regs take the new selection.
  - When load=0, outputs hold unchanged. Hold stability is required while grant_valid_o!=0 and grant_ready_i=0.
- Latency: pending or bypass to grant_valid_o is 1 cycle. req_set_i to eligibility is 1 cycle; req_set_i bits are never candidates in their arrival cycle.
- pending_next = (pending & ~granted_mask) | req_set_i | lost_bps_mask.
  - granted_mask covers pending entries placed in slots.
  - lost_bps_mask is the one-hot of new_req_index_i for valid lanes with new_grant_o=0, whether they lost on load=0 or on a full slot set.
- flush_i=1 has priority over everything except rst: pending<=0, grant_valid_o<=0, new_grant_o=0, and bypass and req_set_i inputs in that cycle are discarded.
- Illegal inputs, caught by assertions only: a new_req_index_i equal to a pending bit or a req_set_i bit; duplicate indices across valid lanes; req_set_i overlapping pending.
- Empty window with no bypass and load=1: all slots go invalid next cycle.

Decomposition:
- Shared rcu package: window index typedef derived from PRIORITY_WIDTH, GRANT_NUM/BPS_NUM defaults.
- Sub-module oldestn_picker: purely combinational. It rotates the candidate vector by priority_fix_i, appends the bypass bits, performs iterative take-first GRANT_NUM times (mask out the previous winner), and outputs per-slot one-hot plus encoded index.
- The top level holds the pending register, output register, load logic and flush.

Test Plan:
1. Reset, then head=6, req_set_i=8'b1100_0101, no bypass, ready=1. Next cycle candidates rank 6,7,0,2; the cycle after, slots={6,7} valid, pending=8'b0000_0101.
2. Pending=8'b0000_0001, head=0, lane0 idx=4 and lane1 idx=5 valid, GRANT_NUM=2. new_grant_o=2'b01; next cycle slots={0,4}, bps=2'b10, pending gains bit5.
3. Hold grant_ready_i=0 with slots valid for 3 cycles, presenting lane0 idx=3. Outputs stay stable, new_grant_o=0, bit3 enters pending; on release, idx 3 is granted in age order.
4. Head=7, pending=8'b1000_0001, ready=1 → slots={7,0}. This checks wrap-around.
5. flush_i with pending=8'hFF and slots valid, plus lane0 valid. Next cycle pending=0, grant_valid_o=0, lane0 is not captured.
6. Assert rst mid-handshake with valid held and ready=0. The next cycle shows all outputs and pending at 0, and new_grant_o=0 during reset.
